// File: rtl/decode_pkg.sv
// Shared constants, FSM state type and lane helpers for the decode issue sequencer.
package decode_pkg;
    localparam int INST_W     = 32;
    localparam int PKT_LANES  = 4;
    localparam int PKT_W      = 128;
    localparam int LANE_IDX_W = 2;

    // Lane valid bit positions inside the fetch mask (lane0 is the MSB)
    localparam int LANE0_BIT = 3;
    localparam int LANE1_BIT = 2;
    localparam int LANE2_BIT = 1;
    localparam int LANE3_BIT = 0;

    localparam logic [31:0] LANE_PC_STRIDE = 32'd4;

    typedef enum logic {EMPTY, HOLD} seq_state_t;

    function automatic int lane_bit(input int lane);
        case (lane)
            0:       return LANE0_BIT;
            1:       return LANE1_BIT;
            2:       return LANE2_BIT;
            default: return LANE3_BIT;
        endcase
    endfunction

    function automatic logic [INST_W-1:0] lane_inst(input logic [PKT_W-1:0] pkt,
                                                    input logic [LANE_IDX_W-1:0] lane);
        case (lane)
            2'd0:    return pkt[127:96];
            2'd1:    return pkt[95:64];
            2'd2:    return pkt[63:32];
            default: return pkt[31:0];
        endcase
    endfunction
endpackage

// File: rtl/decode_issue_seq_if.sv
// Fetch-side and dispatch-side handshake bundle of the decode issue sequencer.
interface decode_issue_seq_if
    import decode_pkg::*;
#(
    parameter int DISPATCH_W = 2
);
    logic                                 pre_valid;
    logic                                 out_ready;
    logic [PKT_W-1:0]                     pkt_in;
    logic [PKT_LANES-1:0]                 pkt_mask_in;
    logic [31:0]                          pkt_pc_in;
    logic                                 out_valid;
    logic                                 next_ready;
    logic [DISPATCH_W-1:0][INST_W-1:0]    disp_inst;
    logic [DISPATCH_W-1:0][31:0]          disp_pc;
    logic [DISPATCH_W-1:0]                disp_slot_vld;

    modport master (
        output pre_valid, pkt_in, pkt_mask_in, pkt_pc_in, next_ready,
        input  out_ready, out_valid, disp_inst, disp_pc, disp_slot_vld
    );

    modport slave (
        input  pre_valid, pkt_in, pkt_mask_in, pkt_pc_in, next_ready,
        output out_ready, out_valid, disp_inst, disp_pc, disp_slot_vld
    );
endinterface

// File: rtl/decode_lane_pick.sv
// Picks the first DISPATCH_W pending lanes in program order and packs them into slots.
module decode_lane_pick
    import decode_pkg::*;
#(
    parameter int DISPATCH_W = 2
) (
    input  logic [PKT_LANES-1:0]                   rem,
    output logic [DISPATCH_W-1:0][LANE_IDX_W-1:0]  slot_lane,
    output logic [DISPATCH_W-1:0]                  slot_vld,
    output logic [PKT_LANES-1:0]                   clr_mask
);
    logic [PKT_LANES-1:0]      lane_v;
    logic [PKT_LANES-1:0][2:0] pre;

    // pre[l] = number of pending lanes ahead of lane l, i.e. the slot it would land in
    for (genvar l = 0; l < PKT_LANES; l++) begin : g_lane
        assign lane_v[l] = rem[lane_bit(l)];
        assign pre[l]    = 3'($countones(lane_v & 4'((1 << l) - 1)));
        assign clr_mask[lane_bit(l)] = lane_v[l] && (pre[l] < 3'(DISPATCH_W));
    end

    for (genvar s = 0; s < DISPATCH_W; s++) begin : g_slot
        logic [PKT_LANES-1:0] hit;
        for (genvar l = 0; l < PKT_LANES; l++) begin : g_hit
            assign hit[l] = lane_v[l] && (pre[l] == 3'(s));
        end
        assign slot_vld[s]  = |hit;
        assign slot_lane[s] = {hit[3] | hit[2], hit[3] | hit[1]};
    end
endmodule

// File: rtl/decode_issue_seq.sv
// Sequences a 4-lane fetch packet into DISPATCH_W-wide dispatch groups.
// Optional perf counters are built when DECODE_SEQ_PERF_EN is defined.
module decode_issue_seq
    import decode_pkg::*;
#(
    parameter int DISPATCH_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    decode_issue_seq_if.slave io
`ifdef DECODE_SEQ_PERF_EN
    ,
    output logic [31:0] perf_pkt_cnt,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    seq_state_t                           state_q, state_d;
    logic [PKT_W-1:0]                     pkt_q;
    logic [31:0]                          pc_q;
    logic [PKT_LANES-1:0]                 rem_q, rem_d, rem_after, clr_mask;
    logic                                 load, fire, accept, last_grp;
    logic [DISPATCH_W-1:0][LANE_IDX_W-1:0] slot_lane;
    logic [DISPATCH_W-1:0]                slot_vld;

    decode_lane_pick #(.DISPATCH_W(DISPATCH_W)) u_pick (
        .rem       (rem_q),
        .slot_lane (slot_lane),
        .slot_vld  (slot_vld),
        .clr_mask  (clr_mask)
    );

    assign rem_after    = rem_q & ~clr_mask;
    assign last_grp     = (rem_after == '0);
    assign io.out_valid = (state_q == HOLD) && !flush && !rst;
    assign fire         = io.out_valid && io.next_ready;
    // Taking the next packet while the last group leaves keeps fetch bubble-free
    assign io.out_ready = !rst && !flush && ((state_q == EMPTY) || (fire && last_grp));
    assign accept       = io.pre_valid && io.out_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        load    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            rem_d   = '0;
        end else if (accept) begin
            load    = |io.pkt_mask_in;
            state_d = (|io.pkt_mask_in) ? HOLD : EMPTY;
            rem_d   = io.pkt_mask_in;
        end else if (fire) begin
            rem_d = rem_after;
            if (last_grp) state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            pkt_q <= io.pkt_in;
            pc_q  <= io.pkt_pc_in;
        end
    end

    for (genvar s = 0; s < DISPATCH_W; s++) begin : g_out
        assign io.disp_inst[s] = lane_inst(pkt_q, slot_lane[s]);
        assign io.disp_pc[s]   = pc_q + 32'(slot_lane[s]) * LANE_PC_STRIDE;
    end
    assign io.disp_slot_vld = slot_vld;

`ifdef DECODE_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_pkt_cnt   <= '0;
            perf_inst_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && |io.pkt_mask_in) perf_pkt_cnt <= perf_pkt_cnt + 32'd1;
            if (fire) perf_inst_cnt <= perf_inst_cnt + 32'($countones(slot_vld));
            if (io.out_valid && !io.next_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_issue_seq.sv
// Scoreboard bench for decode_issue_seq at DISPATCH_W=2; perf checks when DECODE_SEQ_PERF_EN is defined.
module tb_decode_issue_seq;
    import decode_pkg::*;

    localparam int W  = 2;
    localparam int SW = (W > 1) ? $clog2(W) : 1;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    decode_issue_seq_if #(.DISPATCH_W(W)) io ();

`ifdef DECODE_SEQ_PERF_EN
    logic [31:0] perf_pkt_cnt, perf_inst_cnt, perf_stall_cnt;
    logic [31:0] exp_pkt, exp_inst, exp_stall;
`endif

    decode_issue_seq #(.DISPATCH_W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (io)
`ifdef DECODE_SEQ_PERF_EN
        ,
        .perf_pkt_cnt   (perf_pkt_cnt),
        .perf_inst_cnt  (perf_inst_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0]         vld;
        logic [W-1:0][31:0]   inst;
        logic [W-1:0][31:0]   pc;
    } grp_t;

    grp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   accepted;
    int   st;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference split of a packet into dispatch groups, lane order 0..3
    task automatic push_pkt(input logic [127:0] pkt, input logic [3:0] mask, input logic [31:0] pc);
        grp_t g;
        int   s;
        s = 0;
        g.vld = '0; g.inst = '0; g.pc = '0;
        for (int l = 0; l < 4; l++) begin
            if (mask[2'(3 - l)]) begin
                g.vld[SW'(s)]  = 1'b1;
                g.inst[SW'(s)] = pkt[7'(127 - 32 * l) -: 32];
                g.pc[SW'(s)]   = pc + 32'(4 * l);
                s++;
                if (s == W) begin
                    sbq.push_back(g);
                    g.vld = '0; g.inst = '0; g.pc = '0;
                    s = 0;
                end
            end
        end
        if (s != 0) sbq.push_back(g);
    endtask

    task automatic sample();
        grp_t g;
        bit   exp_ov;
        #3;
`ifdef DECODE_SEQ_PERF_EN
        if (!rst) begin
            chk("perf_pkt", perf_pkt_cnt, exp_pkt);
            chk("perf_inst", perf_inst_cnt, exp_inst);
            chk("perf_stall", perf_stall_cnt, exp_stall);
        end
`endif
        exp_ov = (sbq.size() != 0) && !flush && !rst;
        chk("out_valid", io.out_valid, exp_ov);
        if (exp_ov) begin
            g = sbq[0];
            chk("slot_vld", io.disp_slot_vld, g.vld);
            for (int s = 0; s < W; s++) begin
                if (g.vld[SW'(s)]) begin
                    chk($sformatf("inst%0d", s), io.disp_inst[SW'(s)], g.inst[SW'(s)]);
                    chk($sformatf("pc%0d", s), io.disp_pc[SW'(s)], g.pc[SW'(s)]);
                end
            end
            if (io.next_ready) begin
                void'(sbq.pop_front());
`ifdef DECODE_SEQ_PERF_EN
                exp_inst += 32'($countones(g.vld));
`endif
            end
`ifdef DECODE_SEQ_PERF_EN
            else exp_stall += 32'd1;
`endif
        end
        if (io.pre_valid && io.out_ready) begin
            accepted = 1'b1;
            push_pkt(io.pkt_in, io.pkt_mask_in, io.pkt_pc_in);
`ifdef DECODE_SEQ_PERF_EN
            if (io.pkt_mask_in != 4'd0) exp_pkt += 32'd1;
`endif
        end
`ifdef DECODE_SEQ_PERF_EN
        if (rst) begin
            exp_pkt = '0; exp_inst = '0; exp_stall = '0;
        end
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic send(input logic [127:0] pkt, input logic [3:0] mask, input logic [31:0] pc,
                        input bit rnd_nr, output int steps);
        io.pre_valid   = 1'b1;
        io.pkt_in      = pkt;
        io.pkt_mask_in = mask;
        io.pkt_pc_in   = pc;
        accepted = 1'b0;
        steps = 0;
        while (!accepted && steps < 40) begin
            if (rnd_nr) io.next_ready = ($urandom_range(0, 3) != 0);
            step();
            steps++;
        end
        chk("accepted", accepted, 1'b1);
    endtask

    task automatic idle(input int n);
        io.pre_valid = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [127:0] mk_pkt(input logic [7:0] tag);
        return {8'hA0, tag, 16'h0000, 8'hA1, tag, 16'h1111, 8'hA2, tag, 16'h2222, 8'hA3, tag, 16'h3333};
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0;
        io.pre_valid = 1'b0; io.pkt_in = '0; io.pkt_mask_in = '0; io.pkt_pc_in = '0;
        io.next_ready = 1'b1;
`ifdef DECODE_SEQ_PERF_EN
        exp_pkt = '0; exp_inst = '0; exp_stall = '0;
`endif
        adv();
        repeat (2) begin
            sample();
            chk("rst_out_ready", io.out_ready, 1'b0);
            adv();
        end
        rst = 1'b0;
        sample();
        chk("post_rst_ready", io.out_ready, 1'b1);
        adv();

        // Full packet, then back-to-back packets with no bubble
        send(mk_pkt(8'h01), 4'b1111, 32'h1000, 1'b0, st);
        send(mk_pkt(8'h02), 4'b1010, 32'h2000, 1'b0, st);
        chk("b2b_full_steps", st, 2);
        send(mk_pkt(8'h03), 4'b0010, 32'h3000, 1'b0, st);
        chk("b2b_1010_steps", st, 1);
        send(mk_pkt(8'h04), 4'b0000, 32'h4000, 1'b0, st);
        chk("b2b_0010_steps", st, 1);
        io.pre_valid = 1'b0;
        sample();
        chk("zero_mask_ready", io.out_ready, 1'b1);
        adv();

        // Three stall cycles mid-packet
        send(mk_pkt(8'h05), 4'b1111, 32'h5000, 1'b0, st);
        io.pre_valid = 1'b0;
        io.next_ready = 1'b0;
        repeat (3) step();
        io.next_ready = 1'b1;
        sample();
`ifdef DECODE_SEQ_PERF_EN
        chk("perf_stall3", perf_stall_cnt, 32'd3);
`endif
        adv();
        step();

        // Flush with lanes 2-3 pending and a new packet offered
        send(mk_pkt(8'h06), 4'b1111, 32'h6000, 1'b0, st);
        io.pre_valid = 1'b0;
        step();
        flush = 1'b1;
        io.pre_valid = 1'b1; io.pkt_in = mk_pkt(8'h07); io.pkt_mask_in = 4'b1111; io.pkt_pc_in = 32'h7000;
        sample();
        chk("flush_ready", io.out_ready, 1'b0);
        adv();
        sbq.delete();
        flush = 1'b0;
        io.pre_valid = 1'b0;
        sample();
        chk("flush_empty_ready", io.out_ready, 1'b1);
        adv();

        // Reset mid-packet
        send(mk_pkt(8'h08), 4'b1111, 32'h8000, 1'b0, st);
        io.pre_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        sbq.delete();
        rst = 1'b0;
        sample();
        chk("rst_mid_ready", io.out_ready, 1'b1);
        adv();

        // Random masks, PCs near wrap and random decoder back-pressure
        for (int i = 0; i < 12; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
                 (i % 3 == 0) ? 32'hFFFF_FFF8 : $urandom, 1'b1, st);
        end
        io.next_ready = 1'b1;
        idle(6);
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decode_issue_seq.md
# decode_issue_seq

Sequences one 4-wide fetch packet (128-bit instruction word plus 4-bit lane-valid mask) into DISPATCH_W-wide dispatch groups for the single-instruction decoders. It sits between fetch and the per-lane decoders. It replaces the plain one-entry decode holding register with a controller that:
- walks the valid lanes in program order,
- skips invalid lanes,
- back-pressures fetch until the whole packet is consumed,
- supports a pipeline flush.

## Interface
Parameters:
- DISPATCH_W, default 2: instructions dispatched per cycle. Legal values are 1, 2 and 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard the held packet. Priority over everything else.
- pre_valid  in  1  upstream packet valid.
- out_ready  out  1  block can accept a packet this cycle.
- pkt_in  in  128  lane0=[127:96], lane1=[95:64], lane2=[63:32], lane3=[31:0].
- pkt_mask_in  in  4  lane valid; bit3=lane0 … bit0=lane3.
- pkt_pc_in  in  32  PC of lane0; lane k PC = pkt_pc_in + 4k (mod 2^32).
- out_valid  out  1  dispatch group valid.
- next_ready  in  1  decoders accept the group.
- disp_inst  out  32*DISPATCH_W  slot s at [32s+31:32s].
- disp_pc  out  32*DISPATCH_W  PC per slot.
- disp_slot_vld  out  DISPATCH_W  per-slot valid, packed from slot 0 upward.

## Operation
States:
- EMPTY: nothing held.
- HOLD: packet register, PC register and remaining mask `rem` are loaded.

Definitions:
- accept = pre_valid && out_ready.
- fire = out_valid && next_ready.

Group selection (combinational from `rem`):
- Selects the first min(popcount(rem), DISPATCH_W) set lanes in lane order 0→3.
- Selected lanes are placed into slots 0.. in that order. Remaining slots have disp_slot_vld=0, and their data is don't-care.

On fire, the selected bits are cleared from `rem`. When `rem` becomes 0, the state goes to EMPTY unless an accept happens in the same cycle.

Output and transition rules:
- out_valid = HOLD && !flush && !rst.
- out_ready = !rst && !flush && (EMPTY || (fire && rem_after_fire==0)). This gives zero-bubble back-to-back packets.
- Accept with pkt_mask_in==0: the packet is consumed and dropped. The state stays or becomes EMPTY, and nothing is dispatched.
- flush: the next state is EMPTY, `rem` is cleared, no fire occurs, and the incoming packet is not taken (out_ready=0).
- Reset values: state EMPTY, rem=0, out_valid=0, out_ready=0 while rst and 1 the first cycle after. Data registers are not reset.

## Timing
- Accept in cycle t → out_valid in t+1. Outputs are driven from registers plus the selection logic; there is no combinational path from pre_valid or pkt_in.
- A packet with n valid lanes needs ceil(n/DISPATCH_W) fire cycles.
- next_ready low: the group and `rem` are held stable and unchanged.
- out_ready depends combinationally on next_ready (last-group case only).
- Flush mid-packet takes effect at the next edge. out_valid is already 0 in the flush cycle.

## Configuration
- DECODE_SEQ_PERF_EN defined adds three outputs, each 32 bits and wrapping at 2^32:
  - perf_pkt_cnt: +1 per accept with nonzero mask.
  - perf_inst_cnt: +popcount(disp_slot_vld) per fire.
  - perf_stall_cnt: +1 per cycle with out_valid && !next_ready.
- The counters reset to 0 on rst and are unaffected by flush.
- Undefined: the ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Shared package decode_pkg:
  - INST_W=32, PKT_LANES=4, PKT_W=128.
  - Lane-to-bit mapping constants.
  - The lane PC stride (4).
- Sub-module decode_lane_pick:
  - Purely combinational. Inputs are the 4-bit rem and DISPATCH_W.
  - Outputs are per-slot lane index, per-slot valid, and the cleared-bits mask.
- The top holds the state, packet, PC and rem registers, plus the perf counters.

## Test plan
- DISPATCH_W=2, mask=4'b1111, pc=0x1000, next_ready=1 → two fires.
  - Slots pc {0x1000,0x1004}, then {0x1008,0x100C}.
  - out_ready=1 in the second fire cycle, and the next packet is taken with no bubble.
- Mask=4'b1010 (lanes 0 and 2), DISPATCH_W=2 → one fire.
  - Slot0=lane0 pc 0x1000, slot1=lane2 pc 0x1008, disp_slot_vld=2'b11.
- Mask=4'b0010, DISPATCH_W=2 → one fire: slot0=lane2, disp_slot_vld=2'b01.
- Mask=0 accepted → out_valid stays 0 and out_ready stays 1. With PERF_EN, perf_pkt_cnt is unchanged.
- next_ready=0 for 3 cycles mid-packet → outputs stable, rem unchanged. With PERF_EN, perf_stall_cnt=3.
- Flush asserted with lanes 2–3 pending while pre_valid=1 → packet not accepted.
  - Next cycle: EMPTY, out_valid=0, out_ready=1.
  - Rst applied mid-packet → the same EMPTY result.
